// File: rtl/arashi_pkg.sv
// Shared types for the arashi read-cache scheduler.
package arashi_pkg;

   // Thread ids are stored at the widest legal size; each module narrows them
   // to its own THREAD_NUM_WIDTH.
   localparam int unsigned TID_W_MAX            = 4;
   localparam int unsigned THREAD_NUM_WIDTH_DEF = 2;
   localparam int unsigned THREAD_NUM           = 1 << THREAD_NUM_WIDTH_DEF;

   typedef logic [TID_W_MAX-1:0] tid_t;

   typedef struct packed {
      logic valid;
      tid_t tid;
   } rd_tag_t;

endpackage

// File: rtl/arashi_rr_pick.sv
// Round-robin find-first: lowest set bit of elig at or above ptr, wrapping.
module arashi_rr_pick
   import arashi_pkg::*;
#(
   parameter int unsigned W = THREAD_NUM_WIDTH_DEF
) (
   input  logic [(1<<W)-1:0] elig,
   input  logic [W-1:0]      ptr,
   output logic              any,
   output logic [W-1:0]      sel
);

   localparam int unsigned N = 1 << W;

   logic [N-1:0] rot;
   logic [W-1:0] idx;

   // rotate so ptr lands on bit 0, priority-encode, then add ptr back
   always_comb begin
      rot = N'({elig, elig} >> ptr);
      idx = '0;
      for (int unsigned i = N; i > 0; i--) begin
         if (rot[i-1]) idx = W'(i - 1);
      end
      any = |elig;
      sel = idx + ptr;
   end

endmodule

// File: rtl/arashi_rcache_sched.sv
// Schedules per-thread reads onto one fixed-latency cache port and returns
// tagged responses; each thread holds at most one outstanding read.
module arashi_rcache_sched
   import arashi_pkg::*;
#(
   parameter int unsigned THREAD_NUM_WIDTH = 2,
   parameter int unsigned MEM_WIDTH        = 10,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned RD_LATENCY       = 2
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic [(1<<THREAD_NUM_WIDTH)-1:0]       req_valid,
   input  logic [(1<<THREAD_NUM_WIDTH)*MEM_WIDTH-1:0] req_addr,
   output logic [(1<<THREAD_NUM_WIDTH)-1:0]       req_ready,
   input  logic                                   mem_busy,
   output logic                                   mem_ren,
   output logic [MEM_WIDTH-1:0]                   mem_addr,
   input  logic [DATA_WIDTH-1:0]                  mem_rdata,
   output logic                                   rsp_valid,
   output logic [THREAD_NUM_WIDTH-1:0]            rsp_tid,
   output logic [DATA_WIDTH-1:0]                  rsp_data,
   output logic [(1<<THREAD_NUM_WIDTH)-1:0]       pend
);

   localparam int unsigned NT = 1 << THREAD_NUM_WIDTH;

   logic [THREAD_NUM_WIDTH-1:0] ptr;
   logic [THREAD_NUM_WIDTH-1:0] sel;
   logic                        any;
   logic [NT-1:0]               elig;
   logic [NT-1:0]               pend_nxt;
   logic [MEM_WIDTH-1:0]        sel_addr;
   logic                        accept;
   rd_tag_t                     tag [RD_LATENCY+1];

   assign elig = req_valid & ~pend;

   arashi_rr_pick #(
      .W (THREAD_NUM_WIDTH)
   ) u_pick (
      .elig (elig),
      .ptr  (ptr),
      .any  (any),
      .sel  (sel)
   );

   // grant, selected address and next pend vector
   always_comb begin
      req_ready = '0;
      sel_addr  = '0;
      for (int unsigned t = 0; t < NT; t++) begin
         if (sel == THREAD_NUM_WIDTH'(t)) sel_addr = req_addr[t*MEM_WIDTH +: MEM_WIDTH];
      end
      if (rstn && any && !mem_busy) req_ready[sel] = 1'b1;
      accept = |(req_valid & req_ready);
      // clear and set target different threads, so ordering is irrelevant
      pend_nxt = pend;
      if (tag[RD_LATENCY].valid) pend_nxt[THREAD_NUM_WIDTH'(tag[RD_LATENCY].tid)] = 1'b0;
      if (accept) pend_nxt[sel] = 1'b1;
   end

   // issue register, tag pipeline, response register and pend state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mem_ren   <= 1'b0;
         mem_addr  <= '0;
         rsp_valid <= 1'b0;
         rsp_tid   <= '0;
         rsp_data  <= '0;
         pend      <= '0;
         ptr       <= '0;
         for (int unsigned k = 0; k <= RD_LATENCY; k++) tag[k] <= '0;
      end else begin
         mem_ren <= accept;
         if (accept) begin
            mem_addr <= sel_addr;
            ptr      <= sel + 1'b1;
         end
         tag[0].valid <= accept;
         tag[0].tid   <= accept ? tid_t'(sel) : '0;
         for (int unsigned k = 1; k <= RD_LATENCY; k++) tag[k] <= tag[k-1];
         if (tag[RD_LATENCY].valid) begin
            rsp_valid <= 1'b1;
            rsp_tid   <= THREAD_NUM_WIDTH'(tag[RD_LATENCY].tid);
            rsp_data  <= mem_rdata;
         end else begin
            rsp_valid <= 1'b0;
         end
         pend <= pend_nxt;
      end
   end

endmodule
